// File: rtl/fetch_unit_if.sv
// Fetch-side bus bundle: instruction memory request/response, flush/redirect
// from the back end, and the enqueue port into the instruction queue.
interface fetch_unit_if;
  logic        flush;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic        iq_full;
  logic        iq_enqueue;
  logic [63:0] iq_wdata;

  modport master (
    input  flush, redirect_pc, imem_rdata, imem_resp, iq_full,
    output imem_addr, imem_rmask, iq_enqueue, iq_wdata
  );

  modport slave (
    output flush, redirect_pc, imem_rdata, imem_resp, iq_full,
    input  imem_addr, imem_rmask, iq_enqueue, iq_wdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetcher: issues one read, waits for the
// response, parks it in a hold buffer while the queue is full, drains stale replies after flush.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h1eceb000
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_unit_if.master  bus
);

  localparam logic [1:0] S_ISSUE = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  logic [1:0]  state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] hold, hold_nxt;
  logic [31:0] redirect;
  logic [31:0] pc_inc;
  logic [3:0]  rmask;
  logic        enq;
  logic [63:0] wdata;

  // Word alignment is forced here so pc[1:0] can never become non-zero.
  assign redirect = bus.redirect_pc & ~32'h3;
  assign pc_inc   = pc + 32'd4;

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    hold_nxt  = hold;
    rmask     = 4'h0;
    enq       = 1'b0;
    wdata     = 64'h0;
    case (state)
      S_ISSUE: begin
        if (bus.flush) begin
          pc_nxt = redirect;
        end else begin
          rmask     = 4'hF;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.flush) begin
          pc_nxt    = redirect;
          state_nxt = bus.imem_resp ? S_ISSUE : S_DRAIN;
        end else if (bus.imem_resp) begin
          if (!bus.iq_full) begin
            enq       = 1'b1;
            wdata     = {pc, bus.imem_rdata};
            pc_nxt    = pc_inc;
            state_nxt = S_ISSUE;
          end else begin
            hold_nxt  = bus.imem_rdata;
            state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (bus.flush) begin
          pc_nxt    = redirect;
          state_nxt = S_ISSUE;
        end else if (!bus.iq_full) begin
          enq       = 1'b1;
          wdata     = {pc, hold};
          pc_nxt    = pc_inc;
          state_nxt = S_ISSUE;
        end
      end
      default: begin
        // Stale reply from before a flush: swallow it, then resume issuing.
        if (bus.flush) pc_nxt = redirect;
        if (bus.imem_resp) state_nxt = S_ISSUE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_ISSUE;
      pc    <= RESET_PC;
      hold  <= 32'h0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      hold  <= hold_nxt;
    end
  end

  // State is ISSUE while reset is held, so the request is masked by rst_n
  // to keep the bus idle until the first cycle after release.
  assign bus.imem_addr  = pc;
  assign bus.imem_rmask = rst_n ? rmask : 4'h0;
  assign bus.iq_enqueue = enq;
  assign bus.iq_wdata   = wdata;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus hand-written
// asynchronous-reset sequence.
module tb_fetch_unit;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h1eceb000)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic [31:0] redir;
    logic        resp;
    logic [31:0] rdata;
    logic        full;
    logic [3:0]  exp_rmask;
    logic [31:0] exp_addr;
    logic        exp_enq;
    logic [63:0] exp_wdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic fl, input logic [31:0] rd_pc, input logic rsp,
                         input logic [31:0] rd, input logic fu, input logic [3:0] e_rm,
                         input logic [31:0] e_ad, input logic e_en, input logic [63:0] e_wd);
    vec_t v;
    v.flush = fl; v.redir = rd_pc; v.resp = rsp; v.rdata = rd; v.full = fu;
    v.exp_rmask = e_rm; v.exp_addr = e_ad; v.exp_enq = e_en; v.exp_wdata = e_wd;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic fl, input logic [31:0] rd_pc, input logic rsp,
                       input logic [31:0] rd, input logic fu);
    bus.flush       = fl;
    bus.redirect_pc = rd_pc;
    bus.imem_resp   = rsp;
    bus.imem_rdata  = rd;
    bus.iq_full     = fu;
  endtask

  task automatic check_outputs(input string tag, input logic [3:0] e_rm, input logic [31:0] e_ad,
                               input logic e_en, input logic [63:0] e_wd);
    check({tag, ".rmask"}, {60'h0, bus.imem_rmask}, {60'h0, e_rm});
    check({tag, ".addr"},  {32'h0, bus.imem_addr},  {32'h0, e_ad});
    check({tag, ".enq"},   {63'h0, bus.iq_enqueue}, {63'h0, e_en});
    check({tag, ".wdata"}, bus.iq_wdata, e_wd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    //      flush redirect      resp rdata         full  rmask addr          enq  wdata
    // basic fetch, response two cycles after the request
    add_vec(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 4'hF, 32'h1eceb000, 1'b0, 64'h0);
    add_vec(1'b0, 32'h0,        1'b0, 32'hffffffff, 1'b0, 4'h0, 32'h1eceb000, 1'b0, 64'h0);
    add_vec(1'b0, 32'h0,        1'b1, 32'h00000013, 1'b0, 4'h0, 32'h1eceb000, 1'b1, 64'h1eceb000_00000013);
    add_vec(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 4'hF, 32'h1eceb004, 1'b0, 64'h0);
    // queue full at response and for three more cycles
    add_vec(1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 4'h0, 32'h1eceb004, 1'b0, 64'h0);
    add_vec(1'b0, 32'h0,        1'b1, 32'h00100093, 1'b1, 4'h0, 32'h1eceb004, 1'b0, 64'h0);
    add_vec(1'b0, 32'h0,        1'b0, 32'hdeadbeef, 1'b1, 4'h0, 32'h1eceb004, 1'b0, 64'h0);
    add_vec(1'b0, 32'h0,        1'b1, 32'hdeadbeef, 1'b1, 4'h0, 32'h1eceb004, 1'b0, 64'h0);
    add_vec(1'b0, 32'h0,        1'b0, 32'hdeadbeef, 1'b1, 4'h0, 32'h1eceb004, 1'b0, 64'h0);
    add_vec(1'b0, 32'h0,        1'b0, 32'hdeadbeef, 1'b0, 4'h0, 32'h1eceb004, 1'b1, 64'h1eceb004_00100093);
    add_vec(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 4'hF, 32'h1eceb008, 1'b0, 64'h0);
    // flush in WAIT, stale response two cycles later
    add_vec(1'b1, 32'h1eceb100, 1'b0, 32'h0,        1'b0, 4'h0, 32'h1eceb008, 1'b0, 64'h0);
    add_vec(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 4'h0, 32'h1eceb100, 1'b0, 64'h0);
    add_vec(1'b0, 32'h0,        1'b1, 32'h00000bad, 1'b0, 4'h0, 32'h1eceb100, 1'b0, 64'h0);
    add_vec(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 4'hF, 32'h1eceb100, 1'b0, 64'h0);
    // flush coincident with response
    add_vec(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 4'h0, 32'h1eceb100, 1'b0, 64'h0);
    add_vec(1'b1, 32'h1eceb100, 1'b1, 32'h12345678, 1'b0, 4'h0, 32'h1eceb100, 1'b0, 64'h0);
    add_vec(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 4'hF, 32'h1eceb100, 1'b0, 64'h0);
    // misaligned redirect, flush in DRAIN with response, flush in ISSUE
    add_vec(1'b1, 32'h1eceb102, 1'b0, 32'h0,        1'b0, 4'h0, 32'h1eceb100, 1'b0, 64'h0);
    add_vec(1'b1, 32'h1eceb102, 1'b1, 32'h0000dead, 1'b0, 4'h0, 32'h1eceb100, 1'b0, 64'h0);
    add_vec(1'b1, 32'h1eceb102, 1'b0, 32'h0,        1'b0, 4'h0, 32'h1eceb100, 1'b0, 64'h0);
    add_vec(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 4'hF, 32'h1eceb100, 1'b0, 64'h0);
    add_vec(1'b0, 32'h0,        1'b1, 32'h00000073, 1'b0, 4'h0, 32'h1eceb100, 1'b1, 64'h1eceb100_00000073);
    add_vec(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 4'hF, 32'h1eceb104, 1'b0, 64'h0);
    // pc wrap through the hold path
    add_vec(1'b1, 32'hffffffff, 1'b1, 32'h0,        1'b0, 4'h0, 32'h1eceb104, 1'b0, 64'h0);
    add_vec(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 4'hF, 32'hfffffffc, 1'b0, 64'h0);
    add_vec(1'b0, 32'h0,        1'b1, 32'h11111111, 1'b1, 4'h0, 32'hfffffffc, 1'b0, 64'h0);
    add_vec(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 4'h0, 32'hfffffffc, 1'b1, 64'hfffffffc_11111111);
    add_vec(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 4'hF, 32'h00000000, 1'b0, 64'h0);
    // flush drops held word even with queue still full
    add_vec(1'b0, 32'h0,        1'b1, 32'h22222222, 1'b1, 4'h0, 32'h00000000, 1'b0, 64'h0);
    add_vec(1'b1, 32'h1eceb400, 1'b0, 32'h0,        1'b1, 4'h0, 32'h00000000, 1'b0, 64'h0);
    add_vec(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 4'hF, 32'h1eceb400, 1'b0, 64'h0);

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_outputs("reset", 4'h0, 32'h1eceb000, 1'b0, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].flush, vecs[i].redir, vecs[i].resp, vecs[i].rdata, vecs[i].full);
      #1;
      check_outputs($sformatf("vec%0d", i), vecs[i].exp_rmask, vecs[i].exp_addr,
                    vecs[i].exp_enq, vecs[i].exp_wdata);
      @(negedge clk);
    end

    // Asynchronous reset in WAIT while a response is being accepted
    drive(1'b0, 32'h0, 1'b1, 32'h00000055, 1'b0);
    #1;
    check_outputs("pre_async", 4'h0, 32'h1eceb400, 1'b1, 64'h1eceb400_00000055);
    #1 rst_n = 1'b0;
    #1;
    check_outputs("async_rst", 4'h0, 32'h1eceb000, 1'b0, 64'h0);
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_outputs("post_rst_issue", 4'hF, 32'h1eceb000, 1'b0, 64'h0);
    @(negedge clk);
    #1;
    check_outputs("post_rst_wait", 4'h0, 32'h1eceb000, 1'b0, 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h1eceb000, first fetch address after reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 flush  input  1  pipeline flush; redirect fetch to redirect_pc.
REQ-005 redirect_pc  input  32  new fetch PC, sampled only when flush=1.
REQ-006 imem_addr  output  32  instruction memory read address, valid when imem_rmask!=0.
REQ-007 imem_rmask  output  4  read request, 4'hF issues a request, 4'h0 is idle.
REQ-008 imem_rdata  input  32  instruction word, valid when imem_resp=1.
REQ-009 imem_resp  input  1  one-cycle response pulse, at least 1 cycle after request.
REQ-010 iq_full  input  1  instruction queue full flag (combinational from queue state).
REQ-011 iq_enqueue  output  1  enqueue strobe to instruction queue.
REQ-012 iq_wdata  output  64  enqueue payload {pc[31:0], instr[31:0]}, pc in upper half.

Function
REQ-013 Internal state: 32-bit pc, 32-bit hold buffer, FSM with states ISSUE, WAIT, HOLD, DRAIN.
REQ-014 At most one memory request outstanding at any time.
REQ-015 ISSUE, no flush: imem_addr=pc, imem_rmask=4'hF for exactly this cycle, next WAIT.
REQ-016 ISSUE with flush: imem_rmask=0, pc<=redirect_pc, stay ISSUE.
REQ-017 All states other than ISSUE: imem_rmask=0. imem_addr holds pc in every state.
REQ-018 WAIT, imem_resp=1, iq_full=0, no flush: iq_enqueue=1 same cycle, iq_wdata={pc,imem_rdata}, pc<=pc+4, next ISSUE.
REQ-019 WAIT, imem_resp=1, iq_full=1, no flush: hold buffer<=imem_rdata, no enqueue, next HOLD.
REQ-020 HOLD, iq_full=0, no flush: iq_enqueue=1 with {pc,hold buffer}, pc<=pc+4, next ISSUE; while iq_full=1 remain HOLD, outputs stable.
REQ-021 WAIT, flush, imem_resp=0: pc<=redirect_pc, next DRAIN (stale response outstanding).
REQ-022 WAIT, flush and imem_resp=1 same cycle: response discarded, no enqueue, pc<=redirect_pc, next ISSUE.
REQ-023 HOLD with flush: hold buffer dropped, no enqueue, pc<=redirect_pc, next ISSUE.
REQ-024 DRAIN: imem_resp=1 discarded, no enqueue, next ISSUE; flush in DRAIN updates pc<=redirect_pc, stays DRAIN (unless imem_resp=1 same cycle, then ISSUE).
REQ-025 iq_enqueue SHALL be 0 in any cycle with flush=1.
REQ-026 iq_enqueue SHALL be 0 whenever iq_full=1; no instruction lost or duplicated.
REQ-027 pc[1:0] always 2'b00; redirect_pc[1:0] ignored; pc+4 wraps modulo 2^32.
REQ-028 iq_wdata SHALL be 0 when iq_enqueue=0.
REQ-029 imem_rdata ignored when imem_resp=0 or in ISSUE/HOLD states.

Reset
REQ-030 rst_n=0 immediately (asynchronously): state=ISSUE, pc=RESET_PC, hold buffer=0, imem_rmask=0, iq_enqueue=0, iq_wdata=0.
REQ-031 Reset during WAIT/DRAIN abandons outstanding request; environment SHALL not deliver its response after reset release.
REQ-032 First cycle after rst_n rises: request at RESET_PC.

Verification
REQ-033 Reset release, resp 2 cycles after request with rdata 32'h00000013, iq_full=0 -> request addr 32'h1eceb000 rmask 4'hF one cycle; enqueue {32'h1eceb000,32'h00000013} on resp cycle; next request addr 32'h1eceb004.
REQ-034 iq_full=1 at resp and 3 following cycles -> no enqueue, rmask 0 throughout; enqueue of held word on first cycle iq_full=0; next request at pc+4.
REQ-035 flush with redirect_pc 32'h1eceb100 while WAIT, stale resp 2 cycles later -> no enqueue; request at 32'h1eceb100 the cycle after stale resp.
REQ-036 flush coincident with imem_resp -> iq_enqueue=0; request at 32'h1eceb100 next cycle.
REQ-037 rst_n low mid-WAIT without clock edge -> rmask and iq_enqueue 0 immediately; after release request at 32'h1eceb000.
REQ-038 flush with redirect_pc 32'h1eceb102 -> next request addr 32'h1eceb100; enqueued pc 32'h1eceb100.
